// File: rtl/traffic_pkg.sv
// Shared constants, types and the colour decoder for the traffic lamp driver.
package traffic_pkg;

  localparam logic [1:0] RED     = 2'b00;
  localparam logic [1:0] YELLOW  = 2'b01;
  localparam logic [1:0] GREEN   = 2'b10;
  localparam logic [1:0] INVALID = 2'b11;

  // Bit positions inside one approach's {r,y,g} lamp group.
  localparam int unsigned LAMP_R_BIT = 2;
  localparam int unsigned LAMP_Y_BIT = 1;
  localparam int unsigned LAMP_G_BIT = 0;

  localparam int unsigned LAMP_N_BASE = 9;
  localparam int unsigned LAMP_E_BASE = 6;
  localparam int unsigned LAMP_S_BASE = 3;
  localparam int unsigned LAMP_W_BASE = 0;

  localparam int unsigned PH_N_BASE = 6;
  localparam int unsigned PH_E_BASE = 4;
  localparam int unsigned PH_S_BASE = 2;
  localparam int unsigned PH_W_BASE = 0;

  localparam logic [11:0] LAMP_ALL_RED = 12'b100_100_100_100;

  localparam logic [2:0] FC_NONE       = 3'b000;
  localparam logic [2:0] FC_DUAL_GREEN = 3'b001;
  localparam logic [2:0] FC_INVALID    = 3'b010;
  localparam logic [2:0] FC_BOTH       = 3'b011;

  typedef enum logic [1:0] {
    StNormal,
    StFilter,
    StFault
  } state_e;

  // Invalid codes show red so a corrupted aspect never lights a permissive lamp.
  function automatic logic [2:0] lamp_decode(input logic [1:0] code);
    logic [2:0] lamp;
    lamp = '0;
    case (code)
      YELLOW:  lamp[LAMP_Y_BIT] = 1'b1;
      GREEN:   lamp[LAMP_G_BIT] = 1'b1;
      default: lamp[LAMP_R_BIT] = 1'b1;
    endcase
    return lamp;
  endfunction

endpackage

// File: rtl/traffic_blink_gen.sv
// Fail-safe blink prescaler: blink_on_o toggles every BLINK_DIV enabled cycles.
// Disabled or restarted, it parks at count 0 with the lamp phase on.
module traffic_blink_gen
  import traffic_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic restart_i,
  output logic blink_on_o
);

  localparam int unsigned CntW = $clog2(BLINK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(BLINK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            on_q, on_d;

  always_comb begin
    cnt_d = cnt_q;
    on_d  = on_q;
    if (restart_i || !en_i) begin
      cnt_d = '0;
      on_d  = 1'b1;
    end else if (cnt_q == CntMax) begin
      cnt_d = '0;
      on_d  = ~on_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      on_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      on_q  <= on_d;
    end
  end

  assign blink_on_o = on_q;

endmodule

// File: rtl/traffic_lamp_driver.sv
// Lamp driver with conflict monitor and latched fail-safe flashing red.
// Optional macro LAMP_TEST_EN adds lamp_test_i to force all lamps on outside FAULT.
module traffic_lamp_driver
  import traffic_pkg::*;
#(
  parameter int unsigned BLINK_DIV     = 25000000,
  parameter int unsigned CONFLICT_FILT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  phase_i,
  input  logic        fault_clr_i,
`ifdef LAMP_TEST_EN
  input  logic        lamp_test_i,
`endif
  output logic [11:0] lamp_o,
  output logic        fault_o,
  output logic [2:0]  fault_code_o
);

  localparam int unsigned FiltW = $clog2(CONFLICT_FILT + 1);
  localparam logic [FiltW-1:0] FiltMax = FiltW'(CONFLICT_FILT);

  state_e           state_q, state_d;
  logic [FiltW-1:0] filt_q, filt_d, filt_inc;
  logic [7:0]       phase_q;
  logic [11:0]      lamp_q, lamp_d;
  logic             fault_q, fault_d;
  logic [2:0]       fault_code_q, fault_code_d;
  logic [1:0]       code_n, code_e, code_s, code_w;
  logic [2:0]       green_cnt;
  logic             dual_green, invalid, conflict;
  logic             enter_fault, in_fault, blink_on;

  assign code_n = phase_q[PH_N_BASE +: 2];
  assign code_e = phase_q[PH_E_BASE +: 2];
  assign code_s = phase_q[PH_S_BASE +: 2];
  assign code_w = phase_q[PH_W_BASE +: 2];

  assign green_cnt = 3'(code_n == GREEN) + 3'(code_e == GREEN)
                   + 3'(code_s == GREEN) + 3'(code_w == GREEN);
  assign dual_green = (green_cnt >= 3'd2);
  assign invalid    = (code_n == INVALID) || (code_e == INVALID)
                   || (code_s == INVALID) || (code_w == INVALID);
  assign conflict   = dual_green | invalid;
  assign filt_inc   = filt_q + FiltW'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StNormal;
      filt_q       <= '0;
      phase_q      <= '0;
      lamp_q       <= LAMP_ALL_RED;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
    end else begin
      state_q      <= state_d;
      filt_q       <= filt_d;
      phase_q      <= phase_i;
      lamp_q       <= lamp_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  // Next-state logic; a clear request only counts on a conflict-free cycle.
  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    case (state_q)
      StNormal: begin
        if (conflict) begin
          if (CONFLICT_FILT == 1) begin
            state_d = StFault;
          end else begin
            state_d = StFilter;
            filt_d  = FiltW'(1);
          end
        end
      end
      StFilter: begin
        if (!conflict) begin
          state_d = StNormal;
          filt_d  = '0;
        end else if (filt_inc == FiltMax) begin
          state_d = StFault;
          filt_d  = '0;
        end else begin
          filt_d = filt_inc;
        end
      end
      StFault: begin
        if (fault_clr_i && !conflict) begin
          state_d = StNormal;
        end
      end
      default: begin
        state_d = StNormal;
        filt_d  = '0;
      end
    endcase
  end

  assign in_fault    = (state_q == StFault);
  assign enter_fault = (state_d == StFault) && !in_fault;

  traffic_blink_gen #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (in_fault),
    .restart_i (enter_fault),
    .blink_on_o(blink_on)
  );

  // Output logic
  always_comb begin
    fault_d      = (state_d == StFault);
    fault_code_d = fault_code_q;
    if (enter_fault) begin
      case ({invalid, dual_green})
        2'b01:   fault_code_d = FC_DUAL_GREEN;
        2'b10:   fault_code_d = FC_INVALID;
        2'b11:   fault_code_d = FC_BOTH;
        default: fault_code_d = FC_NONE;
      endcase
    end else if (state_d != StFault) begin
      fault_code_d = FC_NONE;
    end

    lamp_d = LAMP_ALL_RED;
    if (in_fault) begin
      lamp_d = '0;
      lamp_d[LAMP_N_BASE + LAMP_R_BIT] = blink_on;
      lamp_d[LAMP_E_BASE + LAMP_R_BIT] = blink_on;
      lamp_d[LAMP_S_BASE + LAMP_R_BIT] = blink_on;
      lamp_d[LAMP_W_BASE + LAMP_R_BIT] = blink_on;
    end
`ifdef LAMP_TEST_EN
    else if (lamp_test_i) begin
      lamp_d = '1;
    end
`endif
    else begin
      lamp_d[LAMP_N_BASE +: 3] = lamp_decode(code_n);
      lamp_d[LAMP_E_BASE +: 3] = lamp_decode(code_e);
      lamp_d[LAMP_S_BASE +: 3] = lamp_decode(code_s);
      lamp_d[LAMP_W_BASE +: 3] = lamp_decode(code_w);
    end
  end

  assign lamp_o       = lamp_q;
  assign fault_o      = fault_q;
  assign fault_code_o = fault_code_q;

endmodule

// File: tb/tb_traffic_lamp_driver.sv
// Self-checking bench for traffic_lamp_driver with a run-length/age based reference model.
module tb_traffic_lamp_driver;

  localparam int unsigned BlinkDiv     = 4;
  localparam int unsigned ConflictFilt = 3;
  localparam logic [11:0] AllRed       = 12'b100_100_100_100;
  localparam logic [7:0]  PhDual       = 8'b10_10_00_00;
`ifdef LAMP_TEST_EN
  localparam bit HasLampTest = 1'b1;
`else
  localparam bit HasLampTest = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  phase_i = '0;
  logic        fault_clr_i = 1'b0;
  logic        lamp_test_i = 1'b0;
  logic [11:0] lamp_o;
  logic        fault_o;
  logic [2:0]  fault_code_o;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  // Reference model state, as seen just after each rising edge.
  logic [7:0]  m_ph1;
  int unsigned m_run;
  bit          m_fault;
  logic [2:0]  m_code;
  int unsigned m_age;
  logic [11:0] m_lamp;

  always #5 clk = ~clk;

  traffic_lamp_driver #(
    .BLINK_DIV    (BlinkDiv),
    .CONFLICT_FILT(ConflictFilt)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .phase_i     (phase_i),
    .fault_clr_i (fault_clr_i),
`ifdef LAMP_TEST_EN
    .lamp_test_i (lamp_test_i),
`endif
    .lamp_o      (lamp_o),
    .fault_o     (fault_o),
    .fault_code_o(fault_code_o)
  );

  function automatic logic [11:0] ref_decode(input logic [7:0] ph);
    logic [11:0] l;
    l = '0;
    for (int a = 0; a < 4; a++) begin
      int unsigned c;
      int unsigned pos;
      c   = int'((ph >> (6 - 2 * a)) & 8'h3);
      pos = 9 - 3 * a;
      if (c == 1) l[pos + 1] = 1'b1;
      else if (c == 2) l[pos] = 1'b1;
      else l[pos + 2] = 1'b1;
    end
    return l;
  endfunction

  task automatic model_reset();
    m_ph1   = '0;
    m_run   = 0;
    m_fault = 1'b0;
    m_code  = 3'b000;
    m_age   = 0;
    m_lamp  = AllRed;
  endtask

  task automatic model_edge();
    int unsigned greens;
    bit          inv;
    bit          conf;
    greens = 0;
    inv    = 1'b0;
    for (int a = 0; a < 4; a++) begin
      int unsigned c;
      c = int'((m_ph1 >> (2 * a)) & 8'h3);
      if (c == 2) greens++;
      if (c == 3) inv = 1'b1;
    end
    conf = (greens >= 2) || inv;
    if (m_fault) m_lamp = (((m_age / BlinkDiv) % 2) == 0) ? AllRed : 12'h000;
    else if (HasLampTest && lamp_test_i) m_lamp = 12'hFFF;
    else m_lamp = ref_decode(m_ph1);
    if (m_fault) begin
      if (fault_clr_i && !conf) begin
        m_fault = 1'b0;
        m_code  = 3'b000;
      end else begin
        m_age++;
      end
    end else begin
      m_run = conf ? m_run + 1 : 0;
      if (m_run >= ConflictFilt) begin
        m_fault = 1'b1;
        m_code  = {1'b0, inv, greens >= 2};
        m_age   = 0;
        m_run   = 0;
      end
    end
    m_ph1 = phase_i;
  endtask

  task automatic step(input logic [7:0] ph, input logic clr);
    phase_i     = ph;
    fault_clr_i = clr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    phase_i     = '0;
    fault_clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_checks++;
    if (lamp_o !== AllRed) $display("FAIL reset_lamp got=%b want=%b", lamp_o, AllRed);
    else n_pass++;
    n_checks++;
    if ({fault_o, fault_code_o} !== 4'b0000)
      $display("FAIL reset_fault got=%b/%b want=0/000", fault_o, fault_code_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    step(8'b10_00_00_00, 1'b0);
    n_checks++;
    if (lamp_o !== AllRed) $display("FAIL latency_early got=%b want=%b", lamp_o, AllRed);
    else n_pass++;
    step(8'b10_00_00_00, 1'b0);
    n_checks++;
    if (lamp_o !== 12'b001_100_100_100)
      $display("FAIL latency_lamp got=%b want=%b", lamp_o, 12'b001_100_100_100);
    else n_pass++;
    n_checks++;
    if (fault_o !== 1'b0) $display("FAIL latency_fault got=%b want=0", fault_o);
    else n_pass++;
  endtask

  task automatic test_dual_green_short();
    logic [7:0] seq [5];
    bit seen;
    seq  = '{PhDual, PhDual, 8'b01_00_10_00, 8'b01_00_10_00, 8'b01_00_10_00};
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(seq[i], 1'b0);
      if (lamp_o === 12'b001_001_100_100) seen = 1'b1;
      n_checks++;
      if ({lamp_o, fault_o, fault_code_o} !== {m_lamp, m_fault, m_code} || fault_o !== 1'b0)
        $display("FAIL dual_short cyc=%0d got lamp=%b fault=%b code=%b want lamp=%b fault=0",
                 i, lamp_o, fault_o, fault_code_o, m_lamp);
      else n_pass++;
    end
    n_checks++;
    if (seen !== 1'b1) $display("FAIL dual_short_visible got=%b want=1", seen);
    else n_pass++;
  endtask

  task automatic test_fault_entry();
    for (int i = 1; i <= 4; i++) begin
      step(PhDual, 1'b0);
      n_checks++;
      if (fault_o !== (i == 4)) $display("FAIL fault_entry step=%0d got=%b want=%b",
                                         i, fault_o, (i == 4));
      else n_pass++;
    end
    n_checks++;
    if (fault_code_o !== 3'b001) $display("FAIL fault_code got=%b want=001", fault_code_o);
    else n_pass++;
    for (int k = 1; k <= 16; k++) begin
      step(PhDual, 1'b0);
      n_checks++;
      if ({lamp_o, fault_o, fault_code_o} !== {m_lamp, m_fault, m_code})
        $display("FAIL blink k=%0d got lamp=%b fault=%b code=%b want lamp=%b fault=%b code=%b",
                 k, lamp_o, fault_o, fault_code_o, m_lamp, m_fault, m_code);
      else n_pass++;
      if (k == 1 || k == 5) begin
        n_checks++;
        if (lamp_o !== ((k == 1) ? AllRed : 12'h000))
          $display("FAIL blink_phase k=%0d got=%b want=%b", k, lamp_o,
                   (k == 1) ? AllRed : 12'h000);
        else n_pass++;
      end
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 4; i++) begin
      step(8'b11_00_00_00, 1'b1);
      n_checks++;
      if (fault_o !== 1'b1 || fault_code_o !== 3'b001)
        $display("FAIL clr_ignored cyc=%0d got fault=%b code=%b want 1/001",
                 i, fault_o, fault_code_o);
      else n_pass++;
    end
    step(8'b00_00_10_00, 1'b1);
    n_checks++;
    if (fault_o !== 1'b1) $display("FAIL clr_stale_invalid got=%b want=1", fault_o);
    else n_pass++;
    step(8'b00_00_10_00, 1'b1);
    n_checks++;
    if (fault_o !== 1'b0 || fault_code_o !== 3'b000)
      $display("FAIL clr_exit got fault=%b code=%b want 0/000", fault_o, fault_code_o);
    else n_pass++;
    step(8'b00_00_10_00, 1'b0);
    n_checks++;
    if (lamp_o !== 12'b100_100_001_100 || {lamp_o, fault_o} !== {m_lamp, m_fault})
      $display("FAIL clr_resume got=%b want=%b", lamp_o, 12'b100_100_001_100);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fault();
    repeat (4) step(PhDual, 1'b0);
    n_checks++;
    if (fault_o !== 1'b1 || fault_o !== m_fault)
      $display("FAIL rst_pre_fault got=%b want=1", fault_o);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (lamp_o !== AllRed || fault_o !== 1'b0 || fault_code_o !== 3'b000)
      $display("FAIL rst_async got lamp=%b fault=%b code=%b want %b/0/000",
               lamp_o, fault_o, fault_code_o, AllRed);
    else n_pass++;
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(PhDual, 1'b0);
      n_checks++;
      if (fault_o !== (i == 4) || {lamp_o, fault_o, fault_code_o} !== {m_lamp, m_fault, m_code})
        $display("FAIL rst_refault step=%0d got fault=%b lamp=%b want fault=%b lamp=%b",
                 i, fault_o, lamp_o, (i == 4), m_lamp);
      else n_pass++;
    end
    n_checks++;
    if (fault_code_o !== 3'b001) $display("FAIL rst_refault_code got=%b want=001", fault_code_o);
    else n_pass++;
  endtask

`ifdef LAMP_TEST_EN
  task automatic test_lamp_test();
    lamp_test_i = 1'b0;
    repeat (2) step(8'b00_10_00_00, 1'b1);
    step(8'b00_10_00_00, 1'b0);
    lamp_test_i = 1'b1;
    step(8'b00_10_00_00, 1'b0);
    n_checks++;
    if (lamp_o !== 12'hFFF) $display("FAIL lamp_test_normal got=%h want=fff", lamp_o);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      step(PhDual, 1'b0);
      n_checks++;
      if ({lamp_o, fault_o, fault_code_o} !== {m_lamp, m_fault, m_code} ||
          (fault_o && i > 4 && (lamp_o & 12'b011_011_011_011) !== 12'h000))
        $display("FAIL lamp_test_fault cyc=%0d got lamp=%b fault=%b want lamp=%b fault=%b",
                 i, lamp_o, fault_o, m_lamp, m_fault);
      else n_pass++;
    end
    lamp_test_i = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [7:0]  ph;
    logic        clr;
    int unsigned hold;
    int unsigned g;
    ph   = '0;
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 5);
        if ($urandom_range(0, 99) < 70) begin
          g = $urandom_range(0, 4);
          for (int a = 0; a < 4; a++) begin
            logic [1:0] c;
            c = (a == int'(g)) ? 2'b10 : 2'($urandom_range(0, 1));
            ph[2 * a +: 2] = c;
          end
        end else begin
          ph = 8'($urandom);
        end
      end
      hold--;
      clr = ($urandom_range(0, 2) == 0);
      if (HasLampTest) lamp_test_i = ($urandom_range(0, 5) == 0);
      step(ph, clr);
      n_checks++;
      if ({lamp_o, fault_o, fault_code_o} !== {m_lamp, m_fault, m_code})
        $display("FAIL random cyc=%0d ph=%b got lamp=%b fault=%b code=%b want lamp=%b fault=%b code=%b",
                 i, ph, lamp_o, fault_o, fault_code_o, m_lamp, m_fault, m_code);
      else n_pass++;
    end
    lamp_test_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_dual_green_short();
    test_fault_entry();
    test_clear();
    test_reset_mid_fault();
`ifdef LAMP_TEST_EN
    test_lamp_test();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
